rll27_encoder: RTL and testbench



---
 rtl/rll27_encoder.sv | 157 +++++++++++++++
 tb/tb_rll27_encoder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rll27_encoder.sv
// Bit-serial RLL(2,7) encoder: parses data bits into variable-length words and
// shifts out two channel bits per data bit as raw code and NRZI line level.
module rll27_encoder #(
   parameter logic NRZI_INIT = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   input  logic din_valid,
   output logic din_ready,
   input  logic flush,
   output logic code_out,
   output logic code_valid,
   output logic nrzi_out,
   output logic busy
);

   // Only the most recent prefix bit is kept: the parse tree fixes every
   // earlier bit once the length is known (len2 starts with 0, len3 is 001).
   logic       prefix_last;
   logic [1:0] prefix_len;
   logic       pend_valid;
   logic [7:0] pend_code;
   logic [3:0] pend_len;
   logic       padding;
   logic [7:0] sh_reg;
   logic [3:0] sh_cnt;
   logic       valid_q;
   logic       nrzi_q;

   logic       take_din;
   logic       bit_valid;
   logic       bit_val;
   logic       word_done;
   logic [7:0] word_code;
   logic [3:0] word_len;
   logic       sh_free;
   logic       nxt_prefix_last;
   logic [1:0] nxt_prefix_len;
   logic       nxt_padding;
   logic       nxt_pend_valid;
   logic [7:0] nxt_pend_code;
   logic [3:0] nxt_pend_len;
   logic [7:0] nxt_sh_reg;
   logic [3:0] nxt_sh_cnt;

   assign din_ready  = ~pend_valid & ~padding;
   assign code_out   = sh_reg[7];
   assign code_valid = valid_q;
   assign nrzi_out   = nrzi_q;
   assign busy       = (prefix_len != 2'd0) | pend_valid | padding | (sh_cnt != 4'd0);

   // Parser: a bit enters either from the handshake or as a pad zero; pads
   // wait while a pending word is held so a completed word always has a home.
   always_comb begin
      take_din        = din_valid & din_ready;
      bit_valid       = take_din | (padding & ~pend_valid);
      bit_val         = take_din & din;
      word_done       = 1'b0;
      word_code       = 8'd0;
      word_len        = 4'd0;
      nxt_prefix_last = prefix_last;
      nxt_prefix_len  = prefix_len;
      if (bit_valid) begin
         nxt_prefix_last = bit_val;
         nxt_prefix_len  = prefix_len + 2'd1;
         case (prefix_len)
            2'd1: begin
               if (prefix_last) begin
                  word_done = 1'b1;
                  word_code = bit_val ? 8'b1000_0000 : 8'b0100_0000;
                  word_len  = 4'd4;
               end
            end
            2'd2: begin
               if (prefix_last) begin
                  word_done = 1'b1;
                  word_code = bit_val ? 8'b0010_0000 : 8'b1001_0000;
                  word_len  = 4'd6;
               end else if (!bit_val) begin
                  word_done = 1'b1;
                  word_code = 8'b0001_0000;
                  word_len  = 4'd6;
               end
            end
            2'd3: begin
               word_done = 1'b1;
               word_code = bit_val ? 8'b0000_1000 : 8'b0010_0100;
               word_len  = 4'd8;
            end
            default: ;
         endcase
         if (word_done) begin
            nxt_prefix_len  = 2'd0;
            nxt_prefix_last = 1'b0;
         end
      end
      // Flush looks at the prefix after this cycle's bit has been appended.
      nxt_padding = (padding & ~word_done) | (flush & (nxt_prefix_len != 2'd0));
   end

   // Output path: the shifter reloads on its last bit so back-to-back words
   // leave no gap; a word finishing while the shifter is busy parks in pending.
   always_comb begin
      sh_free        = (sh_cnt <= 4'd1);
      nxt_pend_valid = pend_valid;
      nxt_pend_code  = pend_code;
      nxt_pend_len   = pend_len;
      nxt_sh_reg     = 8'd0;
      nxt_sh_cnt     = 4'd0;
      if (!sh_free) begin
         nxt_sh_reg = {sh_reg[6:0], 1'b0};
         nxt_sh_cnt = sh_cnt - 4'd1;
      end else if (pend_valid) begin
         nxt_sh_reg     = pend_code;
         nxt_sh_cnt     = pend_len;
         nxt_pend_valid = 1'b0;
      end else if (word_done) begin
         nxt_sh_reg = word_code;
         nxt_sh_cnt = word_len;
      end
      if (word_done && !sh_free) begin
         nxt_pend_valid = 1'b1;
         nxt_pend_code  = word_code;
         nxt_pend_len   = word_len;
      end
   end

   // NRZI level is advanced with the bit being loaded so the transition lines
   // up with the channel 1 that becomes visible on code_out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prefix_last <= 1'b0;
         prefix_len  <= 2'd0;
         pend_valid  <= 1'b0;
         pend_code   <= 8'd0;
         pend_len    <= 4'd0;
         padding     <= 1'b0;
         sh_reg      <= 8'd0;
         sh_cnt      <= 4'd0;
         valid_q     <= 1'b0;
         nrzi_q      <= NRZI_INIT;
      end else begin
         prefix_last <= nxt_prefix_last;
         prefix_len  <= nxt_prefix_len;
         pend_valid  <= nxt_pend_valid;
         pend_code   <= nxt_pend_code;
         pend_len    <= nxt_pend_len;
         padding     <= nxt_padding;
         sh_reg      <= nxt_sh_reg;
         sh_cnt      <= nxt_sh_cnt;
         valid_q     <= (nxt_sh_cnt != 4'd0);
         nrzi_q      <= nrzi_q ^ ((nxt_sh_cnt != 4'd0) & nxt_sh_reg[7]);
      end
   end

endmodule

// File: tb/tb_rll27_encoder.sv
// Directed bench for rll27_encoder: hand-computed codewords, flush padding,
// mid-word reset, and a random stream checked against a table-driven encoder.
module tb_rll27_encoder;

   localparam logic NRZI_INIT = 1'b0;

   logic clk;
   logic rst_n;
   logic din;
   logic din_valid;
   logic din_ready;
   logic flush;
   logic code_out;
   logic code_valid;
   logic nrzi_out;
   logic busy;

   int n_compared   = 0;
   int n_mismatched = 0;

   bit chan[$];
   bit data_q[$];
   bit exp_q[$];

   logic exp_nrzi       = NRZI_INIT;
   int   nrzi_err       = 0;
   int   rll_err        = 0;
   int   idle_code_err  = 0;
   int   run_count      = 0;
   int   cur_run_len    = 0;
   int   last_run_len   = 0;
   int   zeros          = 0;
   bit   run_active     = 0;
   bit   seen_one       = 0;
   bit   ready_low_seen = 0;

   rll27_encoder #(.NRZI_INIT(NRZI_INIT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .flush      (flush),
      .code_out   (code_out),
      .code_valid (code_valid),
      .nrzi_out   (nrzi_out),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Channel monitor: captures bits, tracks expected NRZI and d/k run-lengths.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_nrzi   = NRZI_INIT;
         run_active = 0;
      end else begin
         if (code_valid && code_out) exp_nrzi = ~exp_nrzi;
         if (nrzi_out !== exp_nrzi) nrzi_err++;
         if (!code_valid && code_out !== 1'b0) idle_code_err++;
         if (!din_ready) ready_low_seen = 1;
         if (code_valid) begin
            chan.push_back(code_out);
            if (!run_active) begin
               run_active  = 1;
               run_count++;
               cur_run_len = 0;
               seen_one    = 0;
               zeros       = 0;
            end
            cur_run_len++;
            if (code_out) begin
               if (seen_one && (zeros < 2 || zeros > 7)) rll_err++;
               seen_one = 1;
               zeros    = 0;
            end else begin
               zeros++;
            end
         end else if (run_active) begin
            run_active   = 0;
            last_run_len = cur_run_len;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Sends bits[n-1:0] MSB first, back-to-back whenever din_ready allows.
   // Returns at the falling edge just after the last bit was accepted.
   task automatic applyStimulus(input logic [7:0] bits, input int n);
      @(negedge clk);
      for (int i = n - 1; i >= 0; i--) begin
         int budget = 0;
         din       = bits[i];
         din_valid = 1'b1;
         while (!din_ready && budget < 100) begin
            @(negedge clk);
            budget++;
         end
         if (!din_ready) checkOutput("ready_timeout", 64'd1, 64'd0);
         @(posedge clk);
         @(negedge clk);
      end
      din_valid = 1'b0;
   endtask

   task automatic waitIdle(input int budget);
      int c = 0;
      do begin
         @(negedge clk);
         #1;
         c++;
      end while (busy && c < budget);
      if (busy) checkOutput("idle_timeout", 64'd1, 64'd0);
   endtask

   task automatic pulseFlush();
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   function automatic logic [63:0] packChan();
      logic [63:0] r = 64'd0;
      foreach (chan[i]) r = {r[62:0], chan[i]};
      return r;
   endfunction

   function automatic bit lookupWord(input logic [3:0] w, input int n,
                                     output logic [7:0] c, output int cl);
      c  = 8'd0;
      cl = 0;
      if (n == 2 && w[1:0] == 2'b10) begin c = 8'b0100_0000; cl = 4; end
      if (n == 2 && w[1:0] == 2'b11) begin c = 8'b1000_0000; cl = 4; end
      if (n == 3 && w[2:0] == 3'b000) begin c = 8'b0001_0000; cl = 6; end
      if (n == 3 && w[2:0] == 3'b010) begin c = 8'b1001_0000; cl = 6; end
      if (n == 3 && w[2:0] == 3'b011) begin c = 8'b0010_0000; cl = 6; end
      if (n == 4 && w == 4'b0010) begin c = 8'b0010_0100; cl = 8; end
      if (n == 4 && w == 4'b0011) begin c = 8'b0000_1000; cl = 8; end
      return (cl != 0);
   endfunction

   task automatic buildExpected();
      logic [3:0] w = 4'd0;
      logic [7:0] c;
      int n  = 0;
      int cl;
      exp_q.delete();
      foreach (data_q[i]) begin
         w = {w[2:0], data_q[i]};
         n++;
         if (lookupWord(w, n, c, cl)) begin
            for (int j = 0; j < cl; j++) exp_q.push_back(c[7-j]);
            w = 4'd0;
            n = 0;
         end
      end
      while (n > 0 && n < 5) begin
         w = {w[2:0], 1'b0};
         n++;
         if (lookupWord(w, n, c, cl)) begin
            for (int j = 0; j < cl; j++) exp_q.push_back(c[7-j]);
            n = 0;
         end
      end
   endtask

   logic [7:0]  t3_data [4] = '{8'b0010, 8'b0011, 8'b010, 8'b011};
   int          t3_n    [4] = '{4, 4, 3, 3};
   logic [63:0] t3_code [4] = '{64'b00100100, 64'b00001000, 64'b100100, 64'b001000};
   int          t3_len  [4] = '{8, 8, 6, 6};

   initial begin
      logic [4:0] v_s, c_s, n_s;
      int runs_before;
      int idx, cyc, mism;
      bit acc;

      rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; flush = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_code_out", code_out, 0);
      checkOutput("rst_code_valid", code_valid, 0);
      checkOutput("rst_nrzi", nrzi_out, NRZI_INIT);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_din_ready", din_ready, 1);
      rst_n = 1'b1;

      // Word 10 -> 0100, visible the cycle after the second bit is accepted.
      applyStimulus(8'b10, 2);
      for (int i = 4; i >= 0; i--) begin
         v_s[i] = code_valid; c_s[i] = code_out; n_s[i] = nrzi_out;
         if (i != 0) @(negedge clk);
      end
      checkOutput("w10_valid", v_s, 5'b11110);
      checkOutput("w10_code", c_s, 5'b01000);
      checkOutput("w10_nrzi", n_s, 5'b01111);
      waitIdle(50);
      chan.delete();

      // 1,1,0,0,0 back-to-back: 000 must wait in pending, output stays seamless.
      runs_before    = run_count;
      ready_low_seen = 0;
      applyStimulus(8'b11000, 5);
      waitIdle(50);
      checkOutput("s11000_code", packChan(), 64'b1000000100);
      checkOutput("s11000_len", chan.size(), 10);
      checkOutput("s11000_runs", run_count - runs_before, 1);
      checkOutput("s11000_runlen", last_run_len, 10);
      checkOutput("s11000_ready_low", ready_low_seen, 1);
      chan.delete();

      for (int t = 0; t < 4; t++) begin
         applyStimulus(t3_data[t], t3_n[t]);
         waitIdle(50);
         checkOutput($sformatf("word%0d_code", t), packChan(), t3_code[t]);
         checkOutput($sformatf("word%0d_len", t), chan.size(), t3_len[t]);
         chan.delete();
      end
      // Ones so far: 1 + 2 + 6 = 9, so the line sits at NRZI_INIT ^ 1.
      checkOutput("nrzi_parity", nrzi_out, NRZI_INIT ^ 1'b1);

      applyStimulus(8'b0, 1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      waitIdle(50);
      checkOutput("flush0_code", packChan(), 64'b000100);
      checkOutput("flush0_len", last_run_len, 6);
      checkOutput("flush0_busy", busy, 0);
      chan.delete();

      applyStimulus(8'b001, 3);
      pulseFlush();
      waitIdle(50);
      checkOutput("flush001_code", packChan(), 64'b00100100);
      checkOutput("flush001_len", chan.size(), 8);
      chan.delete();

      // Bit and flush in the same cycle: prefix 1 is padded to 10.
      @(negedge clk);
      din = 1'b1; din_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      din_valid = 1'b0; flush = 1'b0;
      waitIdle(50);
      checkOutput("flush_din_code", packChan(), 64'b0100);
      checkOutput("flush_din_len", chan.size(), 4);
      chan.delete();

      runs_before = run_count;
      pulseFlush();
      repeat (10) @(negedge clk);
      checkOutput("flush_empty_runs", run_count - runs_before, 0);
      checkOutput("flush_empty_busy", busy, 0);
      checkOutput("flush_empty_ready", din_ready, 1);

      // Ones so far 13; word 10 brings it to 14, so the line returns to NRZI_INIT.
      applyStimulus(8'b10, 2);
      waitIdle(50);
      checkOutput("pre_rst_nrzi", nrzi_out, NRZI_INIT);
      chan.delete();

      // Reset during the third channel bit (a 1) of 00100100.
      applyStimulus(8'b0010, 4);
      repeat (2) @(negedge clk);
      checkOutput("mid_bit3", {code_valid, code_out, nrzi_out}, {2'b11, ~NRZI_INIT});
      #1 rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_valid", code_valid, 0);
      checkOutput("mid_rst_nrzi", nrzi_out, NRZI_INIT);
      checkOutput("mid_rst_ready", din_ready, 1);
      checkOutput("mid_rst_busy", busy, 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      chan.delete();
      applyStimulus(8'b10, 2);
      waitIdle(50);
      checkOutput("post_rst_code", packChan(), 64'b0100);
      checkOutput("post_rst_len", chan.size(), 4);
      chan.delete();

      // Random stream with gaps in din_valid, closed with a flush.
      data_q.delete();
      for (int i = 0; i < 2000; i++) data_q.push_back(1'($urandom_range(0, 1)));
      idx = 0;
      cyc = 0;
      while (idx < 2000 && cyc < 20000) begin
         @(negedge clk);
         din_valid = ($urandom_range(0, 3) != 0);
         din       = data_q[idx];
         acc       = din_valid && din_ready;
         @(posedge clk);
         if (acc) idx++;
         cyc++;
      end
      checkOutput("rand_accepted", idx, 2000);
      @(negedge clk);
      din_valid = 1'b0;
      flush     = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      waitIdle(200);
      buildExpected();
      mism = 0;
      for (int i = 0; i < chan.size() && i < exp_q.size(); i++)
         if (chan[i] != exp_q[i]) mism++;
      checkOutput("rand_len", chan.size(), exp_q.size());
      checkOutput("rand_bits", mism, 0);

      checkOutput("nrzi_track", nrzi_err, 0);
      checkOutput("rll_d2_k7", rll_err, 0);
      checkOutput("idle_code_zero", idle_code_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
